avalon_sdr_agent: RTL and testbench



---
 rtl/avalon_sdr_agent_pkg.sv | 28 ++
 rtl/avalon_rsp_fifo.sv | 61 ++++++
 rtl/avalon_sdr_agent.sv | 149 ++++++++++++++
 tb/tb_avalon_sdr_agent.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_sdr_agent_pkg.sv
// Shared constants, handshake state type and byte-merge helper for the
// Avalon-MM SDRAM stand-in agent.
package avalon_sdr_agent_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] ERR_DATA = 16'hBAD0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    FULL   = 2'd2,
    ACCEPT = 2'd3
  } agent_state_e;

  function automatic logic [DATA_W-1:0] be_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [1:0]        be
  );
    logic [DATA_W-1:0] res;
    if (be[0]) res[7:0] = new_w[7:0];
    else       res[7:0] = old_w[7:0];
    if (be[1]) res[15:8] = new_w[15:8];
    else       res[15:8] = old_w[15:8];
    return res;
  endfunction

endpackage

// File: rtl/avalon_rsp_fifo.sv
// Synchronous FIFO holding read responses until the host side may take them.
module avalon_rsp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  always_comb begin
    do_pop_s  = pop & (count_q != '0);
    do_push_s = push & ((count_q != CNT_FULL) | do_pop_s);
    if (do_push_s) wptr_d = wptr_q + AW'(1);
    else           wptr_d = wptr_q;
    if (do_pop_s)  rptr_d = rptr_q + AW'(1);
    else           rptr_d = rptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only words between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/avalon_sdr_agent.sv
// Avalon-MM responder backing single-word 16-bit reads/writes with an on-chip
// array, with configurable wait states, read latency and response back-pressure.
module avalon_sdr_agent
  import avalon_sdr_agent_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          DEPTH        = 1024,
  parameter int          WAIT_CYCLES  = 1,
  parameter int          READ_LATENCY = 2,
  parameter int          RSP_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          avs_s0_read,
  input  logic                          avs_s0_write,
  input  logic [31:0]                   avs_s0_address,
  input  logic [15:0]                   avs_s0_writedata,
  input  logic [1:0]                    avs_s0_byteenable,
  output logic [15:0]                   avs_s0_readdata,
  output logic                          avs_s0_readdatavalid,
  output logic                          avs_s0_waitrequest,
  input  logic                          rsp_hold,
  output logic                          err_pulse,
  output logic [$clog2(RSP_DEPTH):0]    outstanding
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              OW       = $clog2(RSP_DEPTH) + 1;
  localparam logic [3:0]      WAIT_MAX = 4'(WAIT_CYCLES);
  localparam logic [OW-1:0]   OUT_MAX  = OW'(RSP_DEPTH);

  logic              cmd_s, read_only_s, accept_s, legal_s;
  logic              rd_accept_s, wr_accept_s;
  logic [31:0]       off_s;
  logic [AW-1:0]     idx_s;
  logic [3:0]        wcnt_q, wcnt_d;
  agent_state_e      state_q, state_d;
  logic [OW-1:0]     outstanding_q, outstanding_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [DATA_W-1:0] pd_q [READ_LATENCY];
  logic [DATA_W-1:0] pd_d [READ_LATENCY];
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              rdv_q, rdv_d, err_q, err_d;
  logic              fifo_pop_s, fifo_full_s, fifo_empty_s, fifo_unused_s;
  logic [DATA_W-1:0] fifo_rdata_s;
  logic [OW-1:0]     fifo_count_s;

  // The outstanding cap covers pipeline, FIFO and the readdata register, so
  // blocking new reads at RSP_DEPTH is enough to make FIFO overflow impossible.
  always_comb begin
    cmd_s       = avs_s0_read | avs_s0_write;
    read_only_s = avs_s0_read & ~avs_s0_write;
    off_s       = avs_s0_address - BASE_ADDR;
    legal_s     = ~off_s[0] & (off_s[31:AW+1] == '0);
    idx_s       = off_s[AW:1];
    accept_s    = cmd_s & (wcnt_q == WAIT_MAX)
                & ~(read_only_s & (outstanding_q == OUT_MAX));
    wr_accept_s = accept_s & avs_s0_write & legal_s;
    rd_accept_s = accept_s & read_only_s;
    if (~cmd_s | accept_s)       wcnt_d = 4'd0;
    else if (wcnt_q != WAIT_MAX) wcnt_d = wcnt_q + 4'd1;
    else                         wcnt_d = wcnt_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, STALL, FULL, ACCEPT: begin
        if (accept_s)                state_d = ACCEPT;
        else if (~cmd_s)             state_d = IDLE;
        else if (wcnt_q == WAIT_MAX) state_d = FULL;
        else                         state_d = STALL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pv_d[0] = rd_accept_s;
    if (legal_s) pd_d[0] = mem_q[idx_s];
    else         pd_d[0] = ERR_DATA;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    fifo_pop_s = ~fifo_empty_s & ~rsp_hold;
    rdv_d      = fifo_pop_s;
    if (fifo_pop_s) readdata_d = fifo_rdata_s;
    else            readdata_d = readdata_q;
    // Write wins a read/write collision; the dropped read is the error.
    err_d = accept_s & (~legal_s | (avs_s0_read & avs_s0_write));
    case ({rd_accept_s, rdv_q})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q        <= 4'd0;
      state_q       <= IDLE;
      outstanding_q <= '0;
      pv_q          <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pd_q[i] <= '0;
      readdata_q    <= '0;
      rdv_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wcnt_q        <= wcnt_d;
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      pv_q          <= pv_d;
      pd_q          <= pd_d;
      readdata_q    <= readdata_d;
      rdv_q         <= rdv_d;
      err_q         <= err_d;
    end
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) mem_q[idx_s] <= be_merge(mem_q[idx_s], avs_s0_writedata, avs_s0_byteenable);
  end

  avalon_rsp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (pv_q[READ_LATENCY-1]),
    .wdata (pd_q[READ_LATENCY-1]),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign fifo_unused_s        = fifo_full_s ^ (^fifo_count_s);
  assign avs_s0_waitrequest   = reset | (cmd_s & ~accept_s);
  assign avs_s0_readdata      = readdata_q;
  assign avs_s0_readdatavalid = rdv_q;
  assign err_pulse            = err_q;
  assign outstanding          = outstanding_q;

endmodule

// File: tb/tb_avalon_sdr_agent.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic scored against a word-array/queue reference model.
module tb_avalon_sdr_agent;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 1024;
  localparam int          WAITC = 1;
  localparam int          RLAT  = 2;
  localparam int          RSPD  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        avs_s0_read, avs_s0_write;
  logic [31:0] avs_s0_address;
  logic [15:0] avs_s0_writedata;
  logic [1:0]  avs_s0_byteenable;
  logic [15:0] avs_s0_readdata;
  logic        avs_s0_readdatavalid, avs_s0_waitrequest;
  logic        rsp_hold;
  logic        err_pulse;
  logic [2:0]  outstanding;

  avalon_sdr_agent #(
    .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC),
    .READ_LATENCY(RLAT), .RSP_DEPTH(RSPD)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_s0_read(avs_s0_read), .avs_s0_write(avs_s0_write),
    .avs_s0_address(avs_s0_address), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_byteenable(avs_s0_byteenable), .avs_s0_readdata(avs_s0_readdata),
    .avs_s0_readdatavalid(avs_s0_readdatavalid), .avs_s0_waitrequest(avs_s0_waitrequest),
    .rsp_hold(rsp_hold), .err_pulse(err_pulse), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] exp_q [$];
  int          rsp_cnt = 0;
  logic [15:0] last_rsp = 16'h0;
  logic        rnd_done = 1'b0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] off;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        exp_err;
    logic        has_rsp;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] off,
                              input logic [15:0] wd, input logic [1:0] be,
                              input logic exp_err, input logic has_rsp, input logic [15:0] exp_rd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.off = off; v.wd = wd; v.be = be;
    v.exp_err = exp_err; v.has_rsp = has_rsp; v.exp_rd = exp_rd;
    return v;
  endfunction

  // Reference model: applies one accepted command, returns whether it is an error.
  function automatic logic model_accept(input logic rd, input logic wr, input logic [31:0] addr,
                                        input logic [15:0] wd, input logic [1:0] be);
    logic [31:0] off;
    logic        ok;
    int          w;
    off = addr - BASE;
    ok  = (off[0] == 1'b0) && ((off >> 1) < 32'(DEPTH));
    w   = ok ? int'(off >> 1) : 0;
    if (wr) begin
      if (ok && be[0]) ref_mem[w][7:0]  = wd[7:0];
      if (ok && be[1]) ref_mem[w][15:8] = wd[15:8];
    end else if (rd) begin
      exp_q.push_back(ok ? ref_mem[w] : 16'hBAD0);
    end
    return !ok || (rd && wr);
  endfunction

  // Scoreboard: every response must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && avs_s0_readdatavalid) begin
      rsp_cnt++;
      last_rsp = avs_s0_readdata;
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("rsp_data", 32'(avs_s0_readdata), 32'(exp_q.pop_front()));
    end
  end

  // Called just after a posedge; returns just after the accept edge.
  task automatic bus_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [15:0] wd, input logic [1:0] be,
                         output int stalls, output logic err, output logic exp_err);
    logic acc;
    acc = 1'b0; stalls = 0; err = 1'b0; exp_err = 1'b0;
    avs_s0_read = rd; avs_s0_write = wr; avs_s0_address = addr;
    avs_s0_writedata = wd; avs_s0_byteenable = be;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      if (!avs_s0_waitrequest) begin
        acc = 1'b1;
        exp_err = model_accept(rd, wr, addr, wd, be);
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    err = err_pulse;
    avs_s0_read = 1'b0; avs_s0_write = 1'b0;
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(input int start, input string name);
    int n;
    n = 0;
    while (rsp_cnt <= start && n < 50) begin @(posedge clk); #1; n++; end
    check(name, 32'(rsp_cnt > start), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          st, st5, lat, start, mode, w;
    logic        e, ee, rd, wr;
    logic [31:0] addr;

    reset = 1'b1; rsp_hold = 1'b0;
    avs_s0_read = 1'b0; avs_s0_write = 1'b0; avs_s0_address = 32'h0;
    avs_s0_writedata = 16'h0; avs_s0_byteenable = 2'b00;

    vt[0]  = mk(1'b0, 1'b1, 32'd4,         16'hA5A5, 2'b11, 1'b0, 1'b0, 16'h0000);
    vt[1]  = mk(1'b1, 1'b0, 32'd4,         16'h0000, 2'b11, 1'b0, 1'b1, 16'hA5A5);
    vt[2]  = mk(1'b0, 1'b1, 32'd0,         16'h1234, 2'b11, 1'b0, 1'b0, 16'h0000);
    vt[3]  = mk(1'b0, 1'b1, 32'd0,         16'hFFFF, 2'b10, 1'b0, 1'b0, 16'h0000);
    vt[4]  = mk(1'b1, 1'b0, 32'd0,         16'h0000, 2'b11, 1'b0, 1'b1, 16'hFF34);
    vt[5]  = mk(1'b0, 1'b1, 32'd6,         16'h5555, 2'b11, 1'b0, 1'b0, 16'h0000);
    vt[6]  = mk(1'b0, 1'b1, 32'd6,         16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0000);
    vt[7]  = mk(1'b1, 1'b0, 32'd6,         16'h0000, 2'b11, 1'b0, 1'b1, 16'h5555);
    vt[8]  = mk(1'b0, 1'b1, 32'd2,         16'h2222, 2'b11, 1'b0, 1'b0, 16'h0000);
    vt[9]  = mk(1'b0, 1'b1, 32'd3,         16'h7777, 2'b11, 1'b1, 1'b0, 16'h0000);
    vt[10] = mk(1'b1, 1'b0, 32'd2,         16'h0000, 2'b11, 1'b0, 1'b1, 16'h2222);
    vt[11] = mk(1'b1, 1'b0, 32'd1,         16'h0000, 2'b11, 1'b1, 1'b1, 16'hBAD0);
    vt[12] = mk(1'b1, 1'b0, 32'd2048,      16'h0000, 2'b11, 1'b1, 1'b1, 16'hBAD0);
    vt[13] = mk(1'b1, 1'b1, 32'd8,         16'h00C3, 2'b11, 1'b1, 1'b0, 16'h0000);
    vt[14] = mk(1'b1, 1'b0, 32'd8,         16'h0000, 2'b11, 1'b0, 1'b1, 16'h00C3);
    vt[15] = mk(1'b0, 1'b1, 32'hFFFF_FFFE, 16'h9999, 2'b11, 1'b1, 1'b0, 16'h0000);
    vt[16] = mk(1'b0, 1'b1, 32'd2046,      16'h7E57, 2'b11, 1'b0, 1'b0, 16'h0000);
    vt[17] = mk(1'b0, 1'b1, 32'd2048,      16'h1111, 2'b11, 1'b1, 1'b0, 16'h0000);
    vt[18] = mk(1'b1, 1'b0, 32'd2046,      16'h0000, 2'b11, 1'b0, 1'b1, 16'h7E57);
    vt[19] = mk(1'b1, 1'b0, 32'd4,         16'h0000, 2'b11, 1'b0, 1'b1, 16'hA5A5);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_readdata", 32'(avs_s0_readdata), 32'h0);
    check("rst_rdv", 32'(avs_s0_readdatavalid), 32'd0);
    check("rst_err", 32'(err_pulse), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_waitreq", 32'(avs_s0_waitrequest), 32'd1);
    reset = 1'b0;
    #1;
    check("idle_waitreq", 32'(avs_s0_waitrequest), 32'd0);
    @(posedge clk); #1;

    // Write then read with latency measurement
    bus_cmd(1'b0, 1'b1, BASE + 32'd4, 16'hA5A5, 2'b11, st, e, ee);
    check("lat_wr_stall", 32'(st), 32'(WAITC));
    bus_cmd(1'b1, 1'b0, BASE + 32'd4, 16'h0000, 2'b11, st, e, ee);
    check("lat_rd_stall", 32'(st), 32'(WAITC));
    lat = 0;
    while (!avs_s0_readdatavalid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("rd_latency", 32'(lat), 32'(RLAT + 1));
    check("rd_data", 32'(avs_s0_readdata), 32'hA5A5);
    @(posedge clk); #1;
    check("rd_valid_pulse", 32'(avs_s0_readdatavalid), 32'd0);
    check("rd_data_hold", 32'(avs_s0_readdata), 32'hA5A5);

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      start = rsp_cnt;
      bus_cmd(vt[i].rd, vt[i].wr, BASE + vt[i].off, vt[i].wd, vt[i].be, st, e, ee);
      check($sformatf("vec%0d_stall", i), 32'(st), 32'(WAITC));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      if (vt[i].has_rsp) begin
        wait_rsp(start, $sformatf("vec%0d_rsp_arrives", i));
        check($sformatf("vec%0d_rdata", i), 32'(last_rsp), 32'(vt[i].exp_rd));
      end else begin
        repeat (5) @(posedge clk);
        #1;
        check($sformatf("vec%0d_no_rsp", i), 32'(rsp_cnt), 32'(start));
      end
    end

    // Back-pressure: FIFO full stalls the fifth read until rsp_hold drops
    for (int k = 0; k < 6; k++)
      bus_cmd(1'b0, 1'b1, BASE + 32'(80 + 2 * k), 16'hC000 + 16'(k), 2'b11, st, e, ee);
    drain();
    rsp_hold = 1'b1;
    start = rsp_cnt;
    for (int k = 0; k < 4; k++)
      bus_cmd(1'b1, 1'b0, BASE + 32'(80 + 2 * k), 16'h0000, 2'b11, st, e, ee);
    repeat (RLAT + 2) @(posedge clk);
    #1;
    check("bp_outstanding_full", 32'(outstanding), 32'(RSPD));
    check("bp_no_rsp_while_held", 32'(rsp_cnt), 32'(start));
    fork
      bus_cmd(1'b1, 1'b0, BASE + 32'd88, 16'h0000, 2'b11, st5, e, ee);
      begin repeat (8) @(posedge clk); #2; rsp_hold = 1'b0; end
    join
    check("bp_fifth_stalled", 32'(st5 >= 8), 32'd1);
    bus_cmd(1'b1, 1'b0, BASE + 32'd90, 16'h0000, 2'b11, st, e, ee);
    drain();
    check("bp_rsp_count", 32'(rsp_cnt - start), 32'd6);
    check("bp_outstanding_zero", 32'(outstanding), 32'd0);

    // Reset with reads in flight
    bus_cmd(1'b0, 1'b1, BASE + 32'd100, 16'h5A5A, 2'b11, st, e, ee);
    rsp_hold = 1'b1;
    bus_cmd(1'b1, 1'b0, BASE + 32'd100, 16'h0000, 2'b11, st, e, ee);
    bus_cmd(1'b1, 1'b0, BASE + 32'd4, 16'h0000, 2'b11, st, e, ee);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_outstanding", 32'(outstanding), 32'd0);
    check("mid_rst_waitreq", 32'(avs_s0_waitrequest), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_rdv", 32'(avs_s0_readdatavalid), 32'd0);
    rsp_hold = 1'b0;
    reset = 1'b0;
    start = rsp_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_no_rsp", 32'(rsp_cnt), 32'(start));
    check("post_rst_outstanding", 32'(outstanding), 32'd0);
    bus_cmd(1'b1, 1'b0, BASE + 32'd100, 16'h0000, 2'b11, st, e, ee);
    wait_rsp(start, "post_rst_rsp_arrives");
    check("post_rst_preserved", 32'(last_rsp), 32'h5A5A);

    // Randomized traffic against the reference model
    for (int k = 0; k < 32; k++)
      bus_cmd(1'b0, 1'b1, BASE + 32'(2 * k), 16'($urandom), 2'b11, st, e, ee);
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          mode = $urandom_range(0, 9);
          w    = $urandom_range(0, 31);
          addr = BASE + 32'(2 * w);
          rd   = (mode <= 3) || (mode == 9);
          wr   = (mode >= 4 && mode <= 6) || (mode == 9);
          if (mode == 7 || mode == 8) begin
            rd = $urandom_range(0, 1);
            wr = !rd;
            if (mode == 7) addr = addr + 32'd1;
            else           addr = BASE + 32'(2 * DEPTH + 2 * w);
          end
          bus_cmd(rd, wr, addr, 16'($urandom), 2'($urandom_range(0, 3)), st, e, ee);
          check("rand_err", 32'(e), 32'(ee));
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #2;
          rsp_hold = ($urandom_range(0, 2) == 0);
        end
        rsp_hold = 1'b0;
      end
    join
    drain();
    check("rand_outstanding_zero", 32'(outstanding), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
